fifo_in_write_operation_ctrl: RTL and testbench



---
 rtl/fifo_pkg.sv | 18 +
 rtl/register32_r_en.sv | 25 ++
 rtl/fifo_in_write_operation_ctrl.sv | 113 +++++++++++
 tb/tb_fifo_in_write_operation_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths, types and pointer decode for the input FIFO
package fifo_pkg;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // One-hot slot select for a write pointer value.
  function automatic logic [DEPTH-1:0] addr_decode(input addr_t addr);
    logic [DEPTH-1:0] one;
    one = {{(DEPTH-1){1'b0}}, 1'b1};
    return one << addr;
  endfunction
endpackage

// File: rtl/register32_r_en.sv
// rtl/register32_r_en.sv - 32-bit storage register with load enable and async reset
module register32_r_en
  import fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  data_t data_q;
  data_t data_d;

  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q = data_q;
endmodule

// File: rtl/fifo_in_write_operation_ctrl.sv
// rtl/fifo_in_write_operation_ctrl.sv - storage, pointers, count and status for the 8x32 input FIFO
module fifo_in_write_operation_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] to_reg0,
  output logic [DATA_W-1:0] to_reg1,
  output logic [DATA_W-1:0] to_reg2,
  output logic [DATA_W-1:0] to_reg3,
  output logic [DATA_W-1:0] to_reg4,
  output logic [DATA_W-1:0] to_reg5,
  output logic [DATA_W-1:0] to_reg6,
  output logic [DATA_W-1:0] to_reg7,
  output logic [2:0]        rd_addr,
  output logic [2:0]        wr_addr,
  output logic [3:0]        data_count,
  output logic              full,
  output logic              empty,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err
);
  fifo_pkg::addr_t wr_addr_q, wr_addr_d;
  fifo_pkg::addr_t rd_addr_q, rd_addr_d;
  fifo_pkg::cnt_t  count_q, count_d;
  logic            wr_ack_q, wr_ack_d;
  logic            wr_err_q, wr_err_d;
  logic            rd_ack_q, rd_ack_d;
  logic            rd_err_q, rd_err_d;

  logic            full_w, empty_w;
  logic            push_ok, pop_ok;
  logic [7:0]      load_en;
  logic [DATA_W-1:0] slot_val [8];

  // Status comes straight from the registered count, so it reflects the start of the cycle.
  assign full_w  = (count_q == fifo_pkg::CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);
  assign push_ok = wr_en && !full_w;
  assign pop_ok  = rd_en && !empty_w;
  assign load_en = push_ok ? fifo_pkg::addr_decode(wr_addr_q) : '0;

  always_comb begin
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    count_d   = count_q;
    if (push_ok) wr_addr_d = wr_addr_q + 3'd1;
    if (pop_ok)  rd_addr_d = rd_addr_q + 3'd1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    wr_ack_d = push_ok;
    wr_err_d = wr_en && full_w;
    rd_ack_d = pop_ok;
    rd_err_d = rd_en && empty_w;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      count_q   <= '0;
      wr_ack_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      count_q   <= count_d;
      wr_ack_q  <= wr_ack_d;
      wr_err_q  <= wr_err_d;
      rd_ack_q  <= rd_ack_d;
      rd_err_q  <= rd_err_d;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_slot
    register32_r_en u_reg (
      .clk (clk),
      .rst (reset),
      .en  (load_en[i]),
      .d   (din),
      .q   (slot_val[i])
    );
  end

  assign to_reg0    = slot_val[0];
  assign to_reg1    = slot_val[1];
  assign to_reg2    = slot_val[2];
  assign to_reg3    = slot_val[3];
  assign to_reg4    = slot_val[4];
  assign to_reg5    = slot_val[5];
  assign to_reg6    = slot_val[6];
  assign to_reg7    = slot_val[7];
  assign rd_addr    = rd_addr_q;
  assign wr_addr    = wr_addr_q;
  assign data_count = count_q;
  assign full       = full_w;
  assign empty      = empty_w;
  assign wr_ack     = wr_ack_q;
  assign wr_err     = wr_err_q;
  assign rd_ack     = rd_ack_q;
  assign rd_err     = rd_err_q;
endmodule

// File: tb/tb_fifo_in_write_operation_ctrl.sv
// tb/tb_fifo_in_write_operation_ctrl.sv - directed and random checks of the input FIFO controller
module tb_fifo_in_write_operation_ctrl;
  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [31:0] din;
  logic        rd_en;
  logic [31:0] q_reg [8];
  logic [2:0]  rd_addr, wr_addr;
  logic [3:0]  data_count;
  logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queue of entries plus slot memory and pointers as plain integers.
  logic [31:0] m_mem [8];
  logic [31:0] m_fifo [$];
  int          m_wp, m_rp;
  logic        e_wack, e_werr, e_rack, e_rerr;

  fifo_in_write_operation_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .din        (din),
    .rd_en      (rd_en),
    .to_reg0    (q_reg[0]),
    .to_reg1    (q_reg[1]),
    .to_reg2    (q_reg[2]),
    .to_reg3    (q_reg[3]),
    .to_reg4    (q_reg[4]),
    .to_reg5    (q_reg[5]),
    .to_reg6    (q_reg[6]),
    .to_reg7    (q_reg[7]),
    .rd_addr    (rd_addr),
    .wr_addr    (wr_addr),
    .data_count (data_count),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 32'h0;
    m_fifo.delete();
    m_wp = 0;
    m_rp = 0;
    e_wack = 0; e_werr = 0; e_rack = 0; e_rerr = 0;
  endtask

  task automatic model_apply(input logic we, input logic [31:0] d, input logic re);
    int  cnt;
    bit  pa, pp;
    cnt = m_fifo.size();
    pa = we && (cnt < 8);
    pp = re && (cnt > 0);
    if (pp) begin
      void'(m_fifo.pop_front());
      m_rp = (m_rp + 1) % 8;
    end
    if (pa) begin
      m_fifo.push_back(d);
      m_mem[m_wp] = d;
      m_wp = (m_wp + 1) % 8;
    end
    e_wack = pa;
    e_werr = we && !pa;
    e_rack = pp;
    e_rerr = re && !pp;
  endtask

  task automatic check_all(input string tag);
    int cnt;
    cnt = m_fifo.size();
    for (int i = 0; i < 8; i++)
      check($sformatf("%s.to_reg%0d", tag, i), q_reg[i], m_mem[i]);
    check({tag, ".rd_addr"}, 32'(rd_addr), 32'(m_rp));
    check({tag, ".wr_addr"}, 32'(wr_addr), 32'(m_wp));
    check({tag, ".data_count"}, 32'(data_count), 32'(cnt));
    check({tag, ".full"}, 32'(full), 32'(cnt == 8));
    check({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
    check({tag, ".wr_ack"}, 32'(wr_ack), 32'(e_wack));
    check({tag, ".wr_err"}, 32'(wr_err), 32'(e_werr));
    check({tag, ".rd_ack"}, 32'(rd_ack), 32'(e_rack));
    check({tag, ".rd_err"}, 32'(rd_err), 32'(e_rerr));
  endtask

  task automatic step(input string tag, input logic we, input logic [31:0] d, input logic re);
    wr_en = we;
    din   = d;
    rd_en = re;
    model_apply(we, d, re);
    @(posedge clk);
    #1;
    check_all(tag);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 32'h0;
    #12;
    model_reset();
    check_all("reset0");
    reset = 1'b0;

    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 32'(i), 1'b0);
    check("fill.full_const", 32'(full), 32'd1);
    check("fill.reg7_const", q_reg[7], 32'h8);

    step("push_full", 1'b1, 32'hDEAD, 1'b0);
    check("push_full.reg0_const", q_reg[0], 32'h1);
    step("idle_after_err", 1'b0, 32'h0, 1'b0);

    do_reset();
    step("pop_empty", 1'b0, 32'h0, 1'b1);
    step("push_pop_empty", 1'b1, 32'h5, 1'b1);
    check("push_pop_empty.count_const", 32'(data_count), 32'd1);

    do_reset();
    for (int i = 0; i < 8; i++) step("fill2", 1'b1, 32'h100 + 32'(i), 1'b0);
    step("push_pop_full", 1'b1, 32'hBEEF, 1'b1);
    check("push_pop_full.rd_addr_const", 32'(rd_addr), 32'd1);

    do_reset();
    for (int i = 0; i < 8; i++) step("wrap_fill", 1'b1, 32'h20 + 32'(i), 1'b0);
    for (int i = 0; i < 5; i++) step("wrap_pop", 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) step("wrap_push", 1'b1, 32'hA + 32'(i), 1'b0);
    check("wrap.reg3_const", q_reg[3], 32'hD);
    check("wrap.wr_addr_const", 32'(wr_addr), 32'd4);
    check("wrap.rd_addr_const", 32'(rd_addr), 32'd5);
    check("wrap.count_const", 32'(data_count), 32'd7);

    do_reset();
    for (int i = 0; i < 5; i++) step("pre_async", 1'b1, $urandom, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    #1;
    reset = 1'b0;
    step("first_after_async", 1'b1, 32'h77, 1'b0);
    check("first_after_async.reg0_const", q_reg[0], 32'h77);

    for (int i = 0; i < 400; i++)
      step("random", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 100; i++)
      step("random_biased", ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 3) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
